// File: rtl/mem_pkg.sv
// Shared memory-path types and sizing for the packet buffer read/write paths.
package mem_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned NUM_BLOCKS = 16;
    localparam int unsigned BLOCK_BITS = 32;
    localparam int unsigned BLK_CNT_W  = $clog2(NUM_BLOCKS);

    typedef logic [BLK_CNT_W-1:0] blk_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STREAM
    } arb_state_t;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Requester-side and read-controller-side signal bundle for mem_read_arbiter.
// slave: the arbiter's view; master: the environment (requesters + controller).
interface mem_read_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]                        req_i;
    logic [NUM_REQ-1:0][mem_pkg::ADDR_W-1:0]   req_addr_i;
    mem_pkg::blk_cnt_t [NUM_REQ-1:0]           req_size_i;
    logic [NUM_REQ-1:0]                        gnt_o;
    logic [mem_pkg::BLOCK_BITS-1:0]            rd_data_o;
    logic [NUM_REQ-1:0]                        rd_valid_o;
    logic [NUM_REQ-1:0]                        done_o;
    logic [NUM_REQ-1:0]                        err_o;
    logic                                      ctrl_re_o;
    logic [mem_pkg::ADDR_W-1:0]                ctrl_addr_o;
    mem_pkg::blk_cnt_t                         ctrl_size_o;
    logic                                      ctrl_valid_i;
    logic [mem_pkg::BLOCK_BITS-1:0]            ctrl_data_i;
    logic                                      ctrl_busy_i;

    modport slave (
        input  req_i, req_addr_i, req_size_i, ctrl_valid_i, ctrl_data_i, ctrl_busy_i,
        output gnt_o, rd_data_o, rd_valid_o, done_o, err_o, ctrl_re_o, ctrl_addr_o,
               ctrl_size_o
    );

    modport master (
        output req_i, req_addr_i, req_size_i, ctrl_valid_i, ctrl_data_i, ctrl_busy_i,
        input  gnt_o, rd_data_o, rd_valid_o, done_o, err_o, ctrl_re_o, ctrl_addr_o,
               ctrl_size_o
    );

endinterface

// File: rtl/mem_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Shared by the read and write paths.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    int unsigned       cand;
    logic [IDX_W-1:0]  cand_idx;

    // Scan NUM_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand     = (32'(ptr) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid         = 1'b1;
                idx           = cand_idx;
                gnt[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin sharing of one memory read controller among NUM_REQ requesters.
// One burst in flight at a time; returned blocks are steered to the owner.
// Optional stall timeout enabled by defining MEM_RD_ARB_TIMEOUT_EN.
module mem_read_arbiter import mem_pkg::*; #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_read_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0]  owner_oh_q, owner_oh_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    blk_cnt_t            size_q, size_d;
    blk_cnt_t            beat_q, beat_d;

    logic [NUM_REQ-1:0]  sel_gnt;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_valid;

    logic [NUM_REQ-1:0]  gnt, rd_valid, done, err;
    logic                ctrl_re;
    logic                timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (bus.req_i),
        .ptr   (rr_ptr_q),
        .gnt   (sel_gnt),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

`ifdef MEM_RD_ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [STALL_W-1:0] StallLast = STALL_W'(TIMEOUT_CYC - 1);

    logic [STALL_W-1:0] stall_q, stall_d;

    // Stall counter: cleared on STREAM entry and on every beat, counts idle STREAM cycles.
    always_comb begin
        stall_d = stall_q;
        if (state_q == ISSUE) begin
            stall_d = '0;
        end else if (state_q == STREAM) begin
            stall_d = bus.ctrl_valid_i ? '0 : stall_q + 1'b1;
        end
    end

    // Abort on the cycle that would make TIMEOUT_CYC beat-less cycles in a row.
    assign timeout = (state_q == STREAM) && !bus.ctrl_valid_i && (stall_q == StallLast);

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
`endif

    // Next-state and output decode for the IDLE/ISSUE/STREAM sequence.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        addr_d     = addr_q;
        size_d     = size_q;
        beat_d     = beat_q;
        gnt        = '0;
        rd_valid   = '0;
        done       = '0;
        err        = '0;
        ctrl_re    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_valid && !bus.ctrl_busy_i) begin
                    owner_d    = sel_idx;
                    owner_oh_d = sel_gnt;
                    addr_d     = bus.req_addr_i[sel_idx];
                    size_d     = bus.req_size_i[sel_idx];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                gnt      = owner_oh_q;
                rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                beat_d   = '0;
                if (size_q != '0) begin
                    ctrl_re = 1'b1;
                    state_d = STREAM;
                end else begin
                    // Empty burst completes without touching memory.
                    done    = owner_oh_q;
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (bus.ctrl_valid_i) begin
                    rd_valid = owner_oh_q;
                    if (beat_q == size_q - 1'b1) begin
                        done    = owner_oh_q;
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (timeout) begin
                    err     = owner_oh_q;
                    beat_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and latched burst descriptor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            owner_oh_q <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            beat_q     <= beat_d;
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.rd_valid_o  = rd_valid;
    assign bus.done_o      = done;
    assign bus.ctrl_re_o   = ctrl_re;
    assign bus.ctrl_addr_o = addr_q;
    assign bus.ctrl_size_o = size_q;
    assign bus.rd_data_o   = bus.ctrl_data_i;
`ifdef MEM_RD_ARB_TIMEOUT_EN
    assign bus.err_o       = err;
`else
    assign bus.err_o       = '0;
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a burst model.
module tb_mem_read_arbiter;
    import mem_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_read_arbiter_if #(.NUM_REQ(N)) bus ();

    mem_read_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Burst-level model: a selected burst is first granted, then collects beats.
    bit              m_sel, m_stream;
    int              m_owner, m_size, m_got, m_stall, m_ptr;
    logic [ADDR_W-1:0] m_addr;
    logic [N-1:0]    e_gnt, e_valid, e_done, e_err;
    logic            e_re;
    logic [N-1:0]    seen_gnt;

    always @(negedge clk) begin
        seen_gnt = bus.gnt_o;
        e_gnt = '0; e_valid = '0; e_done = '0; e_err = '0; e_re = 1'b0;
        chk("rd_data_follow", 64'(bus.rd_data_o), 64'(bus.ctrl_data_i));
        if (!rst_n) begin
            m_sel = 0; m_stream = 0; m_ptr = 0; m_got = 0; m_stall = 0;
            chk("reset_outputs_zero", 64'({bus.gnt_o, bus.rd_valid_o, bus.done_o, bus.err_o,
                bus.ctrl_re_o, bus.ctrl_addr_o, bus.ctrl_size_o}), 64'(0));
        end else begin
            if (m_sel && !m_stream) begin
                e_gnt[m_owner] = 1'b1;
                if (m_size != 0) e_re = 1'b1;
                else e_done[m_owner] = 1'b1;
            end
            if (m_stream) begin
                if (bus.ctrl_valid_i) begin
                    e_valid[m_owner] = 1'b1;
                    if (m_got + 1 == m_size) e_done[m_owner] = 1'b1;
                end
`ifdef MEM_RD_ARB_TIMEOUT_EN
                else if (m_stall == TO - 1) e_err[m_owner] = 1'b1;
`endif
            end
            chk("model_gnt", 64'(bus.gnt_o), 64'(e_gnt));
            chk("model_ctrl_re", 64'(bus.ctrl_re_o), 64'(e_re));
            chk("model_rd_valid", 64'(bus.rd_valid_o), 64'(e_valid));
            chk("model_done", 64'(bus.done_o), 64'(e_done));
            chk("model_err", 64'(bus.err_o), 64'(e_err));
            if (m_sel) begin
                chk("model_ctrl_addr", 64'(bus.ctrl_addr_o), 64'(m_addr));
                chk("model_ctrl_size", 64'(bus.ctrl_size_o), 64'(m_size));
            end
            // Advance the model across the coming clock edge.
            if (!m_sel) begin
                if (|bus.req_i && !bus.ctrl_busy_i) begin
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = (m_ptr + k) % N;
                        if (!m_sel && bus.req_i[c]) begin
                            m_sel   = 1;
                            m_owner = c;
                            m_addr  = bus.req_addr_i[c];
                            m_size  = int'(bus.req_size_i[c]);
                        end
                    end
                end
            end else if (!m_stream) begin
                m_ptr = (m_owner + 1) % N;
                if (m_size == 0) m_sel = 0;
                else begin
                    m_stream = 1; m_got = 0; m_stall = 0;
                end
            end else if (bus.ctrl_valid_i) begin
                m_got++;
                m_stall = 0;
                if (m_got == m_size) begin
                    m_sel = 0; m_stream = 0;
                end
            end else begin
                m_stall++;
`ifdef MEM_RD_ARB_TIMEOUT_EN
                if (m_stall == TO) begin
                    m_sel = 0; m_stream = 0;
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_i        = '0;
        bus.req_addr_i   = '0;
        bus.req_size_i   = '0;
        bus.ctrl_valid_i = 1'b0;
        bus.ctrl_data_i  = '0;
        bus.ctrl_busy_i  = 1'b0;
    endtask

    int ord[16];
    int dcnt[N];
    int ngnt, ndone;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gnt", 64'(bus.gnt_o), 64'(0));
        chk("reset_ctrl_re", 64'(bus.ctrl_re_o), 64'(0));
        chk("reset_ctrl_addr", 64'(bus.ctrl_addr_o), 64'(0));
        rst_n = 1'b1;

        // Single requester, size 3.
        tick();
        bus.req_addr_i[0] = 16'h0040; bus.req_size_i[0] = 3; bus.req_i[0] = 1'b1;
        settle(); chk("t1_select_no_gnt", 64'(bus.gnt_o), 64'(0));
        tick(); settle();
        chk("t1_gnt", 64'(bus.gnt_o), 64'h1);
        chk("t1_ctrl_re", 64'(bus.ctrl_re_o), 64'h1);
        chk("t1_ctrl_addr", 64'(bus.ctrl_addr_o), 64'h40);
        chk("t1_ctrl_size", 64'(bus.ctrl_size_o), 64'h3);
        tick(); bus.req_i[0] = 1'b0; bus.ctrl_valid_i = 1'b1; bus.ctrl_data_i = 32'hA1;
        settle(); chk("t1_beat1_valid", 64'(bus.rd_valid_o), 64'h1);
        chk("t1_beat1_done", 64'(bus.done_o), 64'h0);
        chk("t1_beat1_data", 64'(bus.rd_data_o), 64'hA1);
        tick(); bus.ctrl_data_i = 32'hA2;
        settle(); chk("t1_beat2_done", 64'(bus.done_o), 64'h0);
        tick(); bus.ctrl_data_i = 32'hA3;
        settle(); chk("t1_beat3_valid", 64'(bus.rd_valid_o), 64'h1);
        chk("t1_beat3_done", 64'(bus.done_o), 64'h1);
        tick(); settle();
        chk("t1_valid_outside_stream", 64'(bus.rd_valid_o), 64'h0);

        // Zero-size burst from requester 2.
        tick(); bus.ctrl_valid_i = 1'b0;
        bus.req_addr_i[2] = 16'h0123; bus.req_size_i[2] = 0; bus.req_i[2] = 1'b1;
        tick(); settle();
        chk("t2_gnt", 64'(bus.gnt_o), 64'h4);
        chk("t2_done", 64'(bus.done_o), 64'h4);
        chk("t2_no_ctrl_re", 64'(bus.ctrl_re_o), 64'h0);
        tick(); bus.req_i[2] = 1'b0;

        // Busy gating.
        bus.ctrl_busy_i = 1'b1;
        bus.req_addr_i[1] = 16'h0080; bus.req_size_i[1] = 1; bus.req_i[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); settle(); chk("t3_busy_no_gnt", 64'(bus.gnt_o), 64'h0);
        end
        tick(); bus.ctrl_busy_i = 1'b0;
        settle(); chk("t3_select_no_gnt", 64'(bus.gnt_o), 64'h0);
        tick(); settle(); chk("t3_gnt_after_busy", 64'(bus.gnt_o), 64'h2);
        tick(); bus.req_i[1] = 1'b0; bus.ctrl_valid_i = 1'b1;
        settle(); chk("t3_done", 64'(bus.done_o), 64'h2);
        tick(); bus.ctrl_valid_i = 1'b0;

        // Reset after the first of four beats; pointer must restart at 0.
        bus.req_addr_i[1] = 16'h0200; bus.req_size_i[1] = 4; bus.req_i[1] = 1'b1;
        tick(); settle(); chk("t4_gnt", 64'(bus.gnt_o), 64'h2);
        tick(); bus.req_i[1] = 1'b0; bus.ctrl_valid_i = 1'b1;
        settle(); chk("t4_beat1", 64'(bus.rd_valid_o), 64'h2);
        tick(); rst_n = 1'b0;
        settle();
        chk("t4_rst_rd_valid", 64'(bus.rd_valid_o), 64'h0);
        chk("t4_rst_done", 64'(bus.done_o), 64'h0);
        chk("t4_rst_ctrl_size", 64'(bus.ctrl_size_o), 64'h0);
        tick(); tick();
        rst_n = 1'b1; bus.ctrl_valid_i = 1'b0;
        bus.req_addr_i[1] = 16'h0300; bus.req_size_i[1] = 0; bus.req_i[1] = 1'b1;
        bus.req_addr_i[3] = 16'h0310; bus.req_size_i[3] = 0; bus.req_i[3] = 1'b1;
        tick(); settle();
        chk("t4_ptr_reset_gnt", 64'(bus.gnt_o), 64'h2);
        chk("t4_ptr_reset_done", 64'(bus.done_o), 64'h2);
        tick(); bus.req_i[1] = 1'b0;
        tick(); settle(); chk("t4_next_gnt", 64'(bus.gnt_o), 64'h8);
        tick(); bus.req_i[3] = 1'b0;

        // Contention: all four held, size 2, from a fresh pointer.
        rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            bus.req_size_i[i] = 2; bus.req_addr_i[i] = 16'(16'h1000 + i); dcnt[i] = 0;
        end
        bus.req_i = '1; bus.ctrl_valid_i = 1'b1;
        ngnt = 0; ndone = 0;
        for (int cyc = 0; cyc < 200 && ndone < 8; cyc++) begin
            settle();
            for (int i = 0; i < N; i++) begin
                if (bus.gnt_o[i] && ngnt < 16) begin ord[ngnt] = i; ngnt++; end
                if (bus.done_o[i]) begin dcnt[i]++; ndone++; end
            end
            tick();
        end
        chk("t5_done_total", 64'(ndone), 64'd8);
        chk("t5_order0", 64'(ord[0]), 64'd0);
        chk("t5_order1", 64'(ord[1]), 64'd1);
        chk("t5_order2", 64'(ord[2]), 64'd2);
        chk("t5_order3", 64'(ord[3]), 64'd3);
        chk("t5_order4", 64'(ord[4]), 64'd0);
        for (int i = 0; i < N; i++) chk("t5_done_per_req", 64'(dcnt[i]), 64'd2);
        idle_inputs();

        // Randomized traffic; the model process checks every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (seen_gnt[i]) begin
                    bus.req_i[i] = 1'b0;
                end else if (!bus.req_i[i]) begin
                    if ($urandom_range(3) == 0) begin
                        bus.req_addr_i[i] = ADDR_W'($urandom);
                        bus.req_size_i[i] = ($urandom_range(7) == 0) ?
                            blk_cnt_t'($urandom_range(NUM_BLOCKS - 1)) :
                            blk_cnt_t'($urandom_range(3));
                        bus.req_i[i] = 1'b1;
                    end
                end else if ($urandom_range(63) == 0) begin
                    bus.req_i[i] = 1'b0;
                end
            end
            bus.ctrl_busy_i  = ($urandom_range(3) == 0);
            bus.ctrl_valid_i = 1'($urandom_range(1));
            bus.ctrl_data_i  = $urandom;
        end
        tick(); bus.req_i = '0; bus.ctrl_busy_i = 1'b0; bus.ctrl_valid_i = 1'b1;
        repeat (40) tick();
        bus.ctrl_valid_i = 1'b0;

`ifdef MEM_RD_ARB_TIMEOUT_EN
        // Stall timeout: size 4, only two beats delivered.
        tick();
        bus.req_addr_i[0] = 16'h0044; bus.req_size_i[0] = 4; bus.req_i[0] = 1'b1;
        repeat (3) begin
            tick(); settle();
            if (bus.gnt_o[0]) break;
        end
        chk("t7_gnt", 64'(bus.gnt_o), 64'h1);
        tick(); bus.req_i[0] = 1'b0; bus.ctrl_valid_i = 1'b1;
        tick();
        tick(); bus.ctrl_valid_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            settle();
            chk("t7_err", 64'(bus.err_o), (k == 8) ? 64'h1 : 64'h0);
            chk("t7_no_done", 64'(bus.done_o), 64'h0);
            tick();
        end
        bus.ctrl_valid_i = 1'b1;
        settle(); chk("t7_late_beat_dropped", 64'(bus.rd_valid_o), 64'h0);
        tick(); bus.ctrl_valid_i = 1'b0;
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares one memory_read_ctrl instance among NUM_REQ requesters, typically egress port engines fetching frame blocks from the shared packet buffer.
- Arbitrates round-robin and issues one burst command (start address, block count) to the read controller.
- Steers the returned block stream to the winning requester and signals burst completion.
- Exactly one burst is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- TIMEOUT_CYC, 64, stall limit in cycles for an in-flight burst; used only with MEM_RD_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  per-requester request level; held until its gnt_o pulse.
- req_addr_i  in  NUM_REQ x ADDR_W  burst start address; stable while req_i is high.
- req_size_i  in  NUM_REQ x $clog2(NUM_BLOCKS)  burst length in blocks.
- gnt_o  out  NUM_REQ  one-hot, one-cycle pulse: request accepted.
- rd_data_o  out  BLOCK_BITS  shared block data bus.
- rd_valid_o  out  NUM_REQ  one-hot: rd_data_o valid for that requester.
- done_o  out  NUM_REQ  one-cycle pulse: burst finished normally.
- err_o  out  NUM_REQ  one-cycle pulse: burst aborted; constant 0 without the macro.
- ctrl_re_o  out  1  start pulse to the read controller.
- ctrl_addr_o  out  ADDR_W  latched start address.
- ctrl_size_o  out  $clog2(NUM_BLOCKS)  latched block count.
- ctrl_valid_i  in  1  block valid from the read controller.
- ctrl_data_i  in  BLOCK_BITS  block data from the read controller.
- ctrl_busy_i  in  1  read controller is active.

Behaviour:
- States: IDLE, ISSUE, STREAM.
- Reset values: state IDLE; rr_ptr 0; beat counter 0; latched addr/size 0.
- Outputs during reset: all outputs 0, except rd_data_o, which follows ctrl_data_i (combinational).
- Reset mid-burst drops the burst silently: no done_o, no err_o.
- IDLE:
  - If any req_i bit is set and ctrl_busy_i=0, select the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch its addr/size and owner index, then go to ISSUE.
  - If ctrl_busy_i=1, stay in IDLE.
- ISSUE (one cycle):
  - gnt_o[owner]=1.
  - If size!=0: ctrl_re_o=1, go to STREAM.
  - If size==0: no memory request; done_o[owner]=1 in the same cycle; go to IDLE.
  - In both cases rr_ptr <= owner+1, wrapping NUM_REQ-1 -> 0.
- ctrl_addr_o and ctrl_size_o hold the latched values from ISSUE through the end of STREAM.
- STREAM:
  - rd_valid_o[owner] = ctrl_valid_i (combinational, zero added latency).
  - rd_data_o = ctrl_data_i, unconditionally.
  - Each ctrl_valid_i increments beat_cnt.
  - On the valid beat where beat_cnt == size-1: done_o[owner]=1 in that same cycle, beat_cnt cleared, go to IDLE.
  - Requesters that are not the owner never see rd_valid_o.
- Grant latency: req_i rising in IDLE -> gnt_o two cycles later (one cycle to select, then the ISSUE cycle).
- Minimum gap between bursts: 1 IDLE cycle.
- Simultaneous requests: strict round-robin, so each requester waits at most NUM_REQ-1 bursts.
- A request that drops before its grant is legal. It is simply not selected; the latched copy is unaffected once in ISSUE.
- ctrl_valid_i asserted outside STREAM is ignored: no rd_valid_o.
- beat_cnt has width $clog2(NUM_BLOCKS) and never wraps, since size <= NUM_BLOCKS-1.

Optional Feature:
- Macro: MEM_RD_ARB_TIMEOUT_EN.
- With the macro:
  - A stall counter resets on every valid beat and on entry to STREAM.
  - If it reaches TIMEOUT_CYC in STREAM, pulse err_o[owner] (no done_o), clear beat_cnt and go to IDLE.
  - Late beats from the aborted burst arriving afterwards are dropped, because they land outside STREAM.
- Without the macro: no counter logic is built, err_o is tied to 0, and STREAM waits indefinitely.

Decomposition:
- mem_pkg:
  - Reuse ADDR_W, NUM_BLOCKS, BLOCK_BITS.
  - Add the arb_state_t enum {IDLE, ISSUE, STREAM}.
  - Add the typedef blk_cnt_t = logic [$clog2(NUM_BLOCKS)-1:0].
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and ptr; outputs one-hot grant and index; purely combinational; reusable by the write path.

Test Plan:
- Single requester: req_i=0001, addr=0x40, size=3 -> gnt_o[0] two cycles later; ctrl_re_o pulse with ctrl_addr_o=0x40, ctrl_size_o=3; three rd_valid_o[0] beats; done_o[0] on the third beat.
- Contention: req_i=1111 held, every size=2 -> grants in order 0,1,2,3,0; done_o count per requester equal; no rd_valid_o bit to a non-owner.
- Zero size: req_i[2] with size=0 -> gnt_o[2] and done_o[2] in the same cycle; ctrl_re_o stays 0.
- Busy gating: ctrl_busy_i=1 while req_i[1]=1 -> no gnt_o; gnt_o[1] two cycles after busy falls.
- Reset mid-burst: rst_n low after the first of 4 beats -> all outputs 0 immediately; the next request after release is granted from rr_ptr=0.
- Timeout (MEM_RD_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): size=4, only 2 beats delivered -> err_o pulses 8 cycles after the last beat; no done_o; a late beat is not forwarded.
